// File: rtl/staging_burn_sequencer.sv
// staging_burn_sequencer: walks a per-stage table through one shared delta-v unit and accumulates total velocity
module staging_burn_sequencer #(
    parameter int MAX_STAGES = 4,
    parameter int AW         = 2,
    parameter int MW         = 32,
    parameter int VW         = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [MW-1:0] cfg_isp,
    input  logic [MW-1:0] cfg_dry,
    input  logic [MW-1:0] cfg_prop,
    input  logic [MW-1:0] payload,
    input  logic [AW:0]   num_stages,
    input  logic          start,
    output logic          dv_req,
    output logic [MW-1:0] dv_isp,
    output logic [MW-1:0] dv_m0,
    output logic [MW-1:0] dv_mprop,
    input  logic          dv_ack,
    input  logic          dv_done,
    input  logic [VW-1:0] dv_velocity,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [AW:0]   stage_idx,
    output logic [VW-1:0] total_velocity
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [AW:0] MAXN = (AW + 1)'(MAX_STAGES);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    typedef enum logic [2:0] {IDLE, SUM, REQ, WAIT, ACC, FIN} state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] isp_q [MAX_STAGES], isp_d [MAX_STAGES];
    logic [MW-1:0] dry_q [MAX_STAGES], dry_d [MAX_STAGES];
    logic [MW-1:0] prop_q [MAX_STAGES], prop_d [MAX_STAGES];
    logic [MW-1:0] mass_q, mass_d;
    logic [AW:0]   nst_q, nst_d, k_q, k_d;
    logic [VW-1:0] tot_q, tot_d, vel_q, vel_d;
    logic          err_q, err_d;
    logic [1:0]    ec_q, ec_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW-1:0] ka;
    logic [MW+1:0] msum;
    logic [VW:0]   vsum;

    assign ka   = k_q[AW-1:0];
    assign msum = {2'b00, mass_q} + {2'b00, dry_q[ka]} + {2'b00, prop_q[ka]};
    assign vsum = {1'b0, tot_q} + {1'b0, vel_q};

    always_comb begin
        state_d = state_q;
        isp_d   = isp_q;
        dry_d   = dry_q;
        prop_d  = prop_q;
        mass_d  = mass_q;
        nst_d   = nst_q;
        k_d     = k_q;
        tot_d   = tot_q;
        vel_d   = vel_q;
        err_d   = err_q;
        ec_d    = ec_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    isp_d[cfg_addr]  = cfg_isp;
                    dry_d[cfg_addr]  = cfg_dry;
                    prop_d[cfg_addr] = cfg_prop;
                end
                if (start) begin
                    mass_d  = payload;
                    nst_d   = num_stages;
                    k_d     = '0;
                    tot_d   = '0;
                    err_d   = num_stages > MAXN;
                    ec_d    = (num_stages > MAXN) ? 2'd1 : 2'd0;
                    state_d = (num_stages == '0 || num_stages > MAXN) ? FIN : SUM;
                end
            end
            SUM: begin
                if (|msum[MW+1:MW]) begin
                    err_d   = 1'b1;
                    ec_d    = 2'd2;
                    state_d = FIN;
                end else begin
                    mass_d  = msum[MW-1:0];
                    k_d     = (k_q == nst_q - ONE) ? '0 : k_q + ONE;
                    state_d = (k_q == nst_q - ONE) ? REQ : SUM;
                end
            end
            REQ: begin
                tmo_d   = '0;
                state_d = dv_ack ? WAIT : REQ;
            end
            WAIT: begin
                if (dv_done) begin
                    vel_d   = dv_velocity;
                    state_d = ACC;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TMAX) begin
                        err_d   = 1'b1;
                        ec_d    = 2'd3;
                        state_d = FIN;
                    end
                end
            end
            ACC: begin
                if (vsum[VW]) begin
                    tot_d   = '1;
                    err_d   = 1'b1;
                    ec_d    = 2'd2;
                    state_d = FIN;
                end else begin
                    tot_d   = vsum[VW-1:0];
                    mass_d  = mass_q - dry_q[ka] - prop_q[ka];
                    k_d     = k_q + ONE;
                    state_d = (k_d == nst_q) ? FIN : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            state_q <= IDLE;
            isp_q   <= '{default: '0};
            dry_q   <= '{default: '0};
            prop_q  <= '{default: '0};
            mass_q  <= '0;
            nst_q   <= '0;
            k_q     <= '0;
            tot_q   <= '0;
            vel_q   <= '0;
            err_q   <= 1'b0;
            ec_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            isp_q   <= isp_d;
            dry_q   <= dry_d;
            prop_q  <= prop_d;
            mass_q  <= mass_d;
            nst_q   <= nst_d;
            k_q     <= k_d;
            tot_q   <= tot_d;
            vel_q   <= vel_d;
            err_q   <= err_d;
            ec_q    <= ec_d;
            tmo_q   <= tmo_d;
        end
    end

    // request operands come straight off the state so reset drops dv_req without waiting for a clock
    assign dv_req         = state_q == REQ;
    assign dv_isp         = isp_q[ka];
    assign dv_m0          = mass_q;
    assign dv_mprop       = prop_q[ka];
    assign busy           = state_q inside {SUM, REQ, WAIT, ACC};
    assign done           = state_q == FIN;
    assign err            = err_q;
    assign err_code       = ec_q;
    assign stage_idx      = k_q;
    assign total_velocity = tot_q;
endmodule

// File: tb/tb_staging_burn_sequencer.sv
// tb_staging_burn_sequencer: randomized and directed sequences checked against a mass-budget reference model
module tb_staging_burn_sequencer;
    localparam int TIMEOUT = 1024;

    logic        clk = 0;
    logic        resetb;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_isp, cfg_dry, cfg_prop, payload;
    logic [2:0]  num_stages;
    logic        start;
    logic        dv_req;
    logic [31:0] dv_isp, dv_m0, dv_mprop;
    logic        dv_ack, dv_done;
    logic [63:0] dv_velocity;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [2:0]  stage_idx;
    logic [63:0] total_velocity;

    staging_burn_sequencer dut (
        .clk(clk), .resetb(resetb), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_isp(cfg_isp),
        .cfg_dry(cfg_dry), .cfg_prop(cfg_prop), .payload(payload), .num_stages(num_stages),
        .start(start), .dv_req(dv_req), .dv_isp(dv_isp), .dv_m0(dv_m0), .dv_mprop(dv_mprop),
        .dv_ack(dv_ack), .dv_done(dv_done), .dv_velocity(dv_velocity), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .stage_idx(stage_idx), .total_velocity(total_velocity)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] t_isp [4], t_dry [4], t_prop [4];
    logic [63:0] vel [4];
    logic [31:0] rq_isp [$], rq_m0 [$], rq_mp [$];
    int ack_delay = 0, done_delay = 0, unstable = 0;
    bit no_done = 0, spur = 0, poke = 0, co_wr = 0;
    logic [1:0]  co_addr;
    logic [31:0] co_isp, co_dry, co_prop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin : responder
        logic [31:0] ci, cm, cp;
        int idx;
        dv_ack = 0;
        dv_done = 0;
        dv_velocity = 0;
        forever begin
            @(negedge clk);
            dv_ack = 0;
            dv_done = 0;
            if (dv_req === 1'b1 && resetb === 1'b0) begin
                ci = dv_isp; cm = dv_m0; cp = dv_mprop;
                if (spur && ack_delay > 0) begin
                    dv_done = 1;
                    dv_velocity = 64'hDEAD_BEEF_0000_0001;
                end
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge clk);
                    dv_done = 0;
                    if (dv_req !== 1'b1 || dv_isp !== ci || dv_m0 !== cm || dv_mprop !== cp) unstable++;
                end
                dv_ack = 1;
                rq_isp.push_back(dv_isp);
                rq_m0.push_back(dv_m0);
                rq_mp.push_back(dv_mprop);
                idx = rq_m0.size() - 1;
                @(negedge clk);
                dv_ack = 0;
                if (dv_req !== 1'b0) unstable++;
                if (!no_done) begin
                    repeat (done_delay) @(negedge clk);
                    dv_done = 1;
                    dv_velocity = (idx < 4) ? vel[idx] : 64'h0;
                end
            end
        end
    end

    task automatic wr(input int a, input logic [31:0] i, input logic [31:0] d, input logic [31:0] p);
        @(negedge clk);
        cfg_we = 1; cfg_addr = a[1:0]; cfg_isp = i; cfg_dry = d; cfg_prop = p;
        t_isp[a] = i; t_dry[a] = d; t_prop[a] = p;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic run(input int n, input logic [31:0] pl, input string tag);
        int cyc, e_nreq;
        logic [1:0] e_ec;
        logic [64:0] t;
        logic [31:0] e_m0 [4];
        longint unsigned m;
        rq_isp.delete(); rq_m0.delete(); rq_mp.delete();
        unstable = 0;
        @(negedge clk);
        if (co_wr) begin
            cfg_we = 1; cfg_addr = co_addr; cfg_isp = co_isp; cfg_dry = co_dry; cfg_prop = co_prop;
            t_isp[co_addr] = co_isp; t_dry[co_addr] = co_dry; t_prop[co_addr] = co_prop;
        end
        payload = pl; num_stages = 3'(n); start = 1;
        // ignition mass of stage i is payload plus everything still attached above it
        e_ec = 0; e_nreq = 0; t = 0;
        if (n > 4) e_ec = 1;
        else if (n > 0) begin
            for (int i = 0; i < n; i++) begin
                m = 64'(pl);
                for (int j = i; j < n; j++) m += 64'(t_dry[j]) + 64'(t_prop[j]);
                e_m0[i] = m[31:0];
                if (i == 0 && m >= 64'h1_0000_0000) e_ec = 2;
            end
            for (int i = 0; i < n && e_ec == 0; i++) begin
                e_nreq++;
                if (no_done) e_ec = 3;
                else begin
                    t = t + {1'b0, vel[i]};
                    if (t[64]) begin
                        e_ec = 2;
                        t = {1'b0, {64{1'b1}}};
                    end
                end
            end
        end
        @(negedge clk);
        start = 0; cfg_we = 0; cyc = 1;
        while (!done && cyc < 3000) begin
            if (poke && cyc == 3) begin
                start = 1; cfg_we = 1; cfg_addr = 0; payload = 32'h5A5A;
                cfg_isp = 32'h5A5A; cfg_dry = 32'h5A5A; cfg_prop = 32'h5A5A; num_stages = 1;
            end else begin
                start = 0; cfg_we = 0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 0; cfg_we = 0;
        check({tag, " done"}, done, 1);
        if (n == 0 || n > 4) check({tag, " latency"}, cyc, 1);
        else if (ack_delay == 0 && done_delay == 0 && e_ec == 0) check({tag, " latency"}, cyc, 4 * n + 1);
        if (no_done) check({tag, " tmo window"}, cyc >= TIMEOUT && cyc <= TIMEOUT + 16, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " total"}, total_velocity, t[63:0]);
        check({tag, " err"}, err, e_ec != 0);
        check({tag, " err_code"}, err_code, e_ec);
        check({tag, " nreq"}, rq_m0.size(), e_nreq);
        check({tag, " stable"}, unstable, 0);
        for (int i = 0; i < e_nreq; i++) begin
            check($sformatf("%s m0[%0d]", tag, i), rq_m0[i], e_m0[i]);
            check($sformatf("%s mprop[%0d]", tag, i), rq_mp[i], t_prop[i]);
            check($sformatf("%s isp[%0d]", tag, i), rq_isp[i], t_isp[i]);
        end
        @(negedge clk);
        check({tag, " done pulse"}, done, 0);
        check({tag, " total held"}, total_velocity, t[63:0]);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        resetb = 1; cfg_we = 0; cfg_addr = 0; cfg_isp = 0; cfg_dry = 0; cfg_prop = 0;
        payload = 0; num_stages = 0; start = 0;
        for (int i = 0; i < 4; i++) begin
            t_isp[i] = 0; t_dry[i] = 0; t_prop[i] = 0; vel[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst dv_req", dv_req, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst err_code", err_code, 0);
        check("rst stage_idx", stage_idx, 0);
        check("rst total", total_velocity, 0);
        check("rst operands", {dv_isp, dv_m0 | dv_mprop}, 0);
        resetb = 0;

        wr(0, 300, 2000, 7000);
        wr(1, 450, 500, 1500);
        vel[0] = 5000; vel[1] = 3000;
        run(2, 1000, "basic");
        check("basic m0_0 const", rq_m0[0], 12000);
        check("basic m0_1 const", rq_m0[1], 3000);
        check("basic total const", total_velocity, 8000);

        run(0, 1000, "n0");
        run(5, 1000, "n5");

        ack_delay = 7; done_delay = 2; spur = 1;
        run(2, 1000, "ackdly");
        no_done = 1; spur = 0;
        run(1, 1000, "tmo");
        no_done = 0; ack_delay = 0; done_delay = 0;

        wr(0, 100, 32'h8000_0000, 32'h8000_0000);
        run(1, 0, "movf");

        wr(0, 1, 10, 10);
        wr(1, 2, 5, 5);
        vel[0] = 64'h8000_0000_0000_0000; vel[1] = 64'h8000_0000_0000_0000;
        run(2, 100, "sat");

        wr(2, 7, 30, 40);
        vel[0] = 11; vel[1] = 22; vel[2] = 33;
        poke = 1;
        run(3, 50, "poke");
        poke = 0;
        run(3, 50, "postpoke");

        co_wr = 1; co_addr = 1; co_isp = 999; co_dry = 123; co_prop = 456;
        run(2, 10, "cowr");
        co_wr = 0;

        done_delay = 20;
        @(negedge clk);
        payload = 1000; num_stages = 2; start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 50 && rq_m0.size() == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        resetb = 1;
        #1;
        check("midrst dv_req", dv_req, 0);
        check("midrst busy", busy, 0);
        check("midrst m0", dv_m0, 0);
        check("midrst stage_idx", stage_idx, 0);
        @(negedge clk);
        resetb = 0;
        for (int i = 0; i < 4; i++) begin
            t_isp[i] = 0; t_dry[i] = 0; t_prop[i] = 0;
        end
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            seen |= done | busy;
        end
        check("late done ignored", seen, 0);
        check("late done total", total_velocity, 0);
        done_delay = 0;
        wr(0, 300, 2000, 7000);
        vel[0] = 777;
        run(1, 1000, "afterrst");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) begin
                wr(i, $urandom, $urandom_range(0, 1 << 20), $urandom_range(0, 1 << 20));
                vel[i] = {$urandom, $urandom} >> 2;
            end
            ack_delay = $urandom_range(0, 3);
            done_delay = $urandom_range(0, 3);
            spur = ack_delay > 0 && $urandom_range(0, 1) == 1;
            run($urandom_range(1, 4), $urandom_range(0, 1 << 20), $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
